// File: rtl/hazard_stall_controller_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller.
// The master side is the pipeline; the slave side is the controller.
interface hazard_stall_controller_if;
    logic       MemRead_ID_EX;
    logic [4:0] Rt_ID_EX;
    logic [4:0] Rs_IF_ID;
    logic [4:0] Rt_IF_ID;
    logic       Uses_Rt_ID;
    logic       Branch_Taken_EX;
    logic       MulDiv_Start_EX;
    logic       MulDiv_Is_Div_EX;
    logic       HiLo_Read_ID;
    logic       MulDiv_Op_ID;
    logic       PC_Write;
    logic       IF_ID_Write;
    logic       IF_ID_Flush;
    logic       ID_EX_Flush;
    logic       MulDiv_Busy;
    logic       MulDiv_Done;
    logic       MulDiv_Sel_Div;

    modport master (
        output MemRead_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, Uses_Rt_ID,
        output Branch_Taken_EX, MulDiv_Start_EX, MulDiv_Is_Div_EX,
        output HiLo_Read_ID, MulDiv_Op_ID,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
        input  MulDiv_Busy, MulDiv_Done, MulDiv_Sel_Div
    );

    modport slave (
        input  MemRead_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, Uses_Rt_ID,
        input  Branch_Taken_EX, MulDiv_Start_EX, MulDiv_Is_Div_EX,
        input  HiLo_Read_ID, MulDiv_Op_ID,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
        output MulDiv_Busy, MulDiv_Done, MulDiv_Sel_Div
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use stalls,
// taken-branch flushes and sequencing of the multi-cycle MULTU/DIVU unit.
module hazard_stall_controller #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    hazard_stall_controller_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               sel_div_r;
    logic               sel_div_nxt_s;
    logic               busy_r;
    logic               done_r;
    logic               load_use_s;
    logic               hilo_stall_s;
    logic               stall_s;

    // FSM state, counter and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            count_r   <= '0;
            sel_div_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            count_r   <= count_nxt_s;
            sel_div_r <= sel_div_nxt_s;
            busy_r    <= (state_nxt_s == ST_BUSY);
            done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    // Next-state logic; a Start in BUSY is ignored, a Start in DONE restarts
    always_comb begin
        state_nxt_s   = state_r;
        count_nxt_s   = count_r;
        sel_div_nxt_s = sel_div_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.MulDiv_Start_EX) begin
                    count_nxt_s   = bus.MulDiv_Is_Div_EX ? DIV_LOAD : MULT_LOAD;
                    sel_div_nxt_s = bus.MulDiv_Is_Div_EX;
                    state_nxt_s   = ST_BUSY;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (count_r == CNT_W'(1)) begin
                    count_nxt_s = '0;
                    state_nxt_s = ST_DONE;
                end else begin
                    count_nxt_s = count_r - CNT_W'(1);
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                count_nxt_s = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Hazard detection; HI/LO readers are released in the DONE cycle
    always_comb begin
        load_use_s   = bus.MemRead_ID_EX && (bus.Rt_ID_EX != 5'd0) &&
                       ((bus.Rt_ID_EX == bus.Rs_IF_ID) ||
                        (bus.Uses_Rt_ID && (bus.Rt_ID_EX == bus.Rt_IF_ID)));
        hilo_stall_s = (bus.HiLo_Read_ID || bus.MulDiv_Op_ID) &&
                       ((state_r == ST_BUSY) || bus.MulDiv_Start_EX);
        stall_s      = load_use_s || hilo_stall_s;
    end

    // Pipeline control with branch flush taking priority over stalls
    always_comb begin
        bus.PC_Write    = 1'b1;
        bus.IF_ID_Write = 1'b1;
        bus.IF_ID_Flush = 1'b0;
        bus.ID_EX_Flush = 1'b0;
        if (bus.Branch_Taken_EX) begin
            bus.IF_ID_Flush = 1'b1;
            bus.ID_EX_Flush = 1'b1;
        end else if (stall_s) begin
            bus.PC_Write    = 1'b0;
            bus.IF_ID_Write = 1'b0;
            bus.ID_EX_Flush = 1'b1;
        end else begin
            bus.PC_Write    = 1'b1;
            bus.IF_ID_Write = 1'b1;
        end
    end

    assign bus.MulDiv_Busy    = busy_r;
    assign bus.MulDiv_Done    = done_r;
    assign bus.MulDiv_Sel_Div = sel_div_r;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios plus
// randomized traffic compared against a cycle-numbered behavioural model.
module tb_hazard_stall_controller;

    localparam int MC = 4;
    localparam int DC = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;

    // Model: an operation is described by the cycle it started and the cycle it completes
    int   cyc      = 0;
    int   start_at = -1;
    int   done_at  = -1;
    bit   m_sel    = 1'b0;

    hazard_stall_controller_if hif ();

    hazard_stall_controller #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired (got no finish, want finish)");
        $fatal(1);
    end

    function automatic bit m_busy();
        return (start_at >= 0) && (cyc > start_at) && (cyc < done_at);
    endfunction

    function automatic bit m_done();
        return (cyc == done_at);
    endfunction

    task automatic model_reset();
        start_at = -1;
        done_at  = -1;
        m_sel    = 1'b0;
    endtask

    task automatic model_advance();
        if (rst && !m_busy() && hif.MulDiv_Start_EX) begin
            start_at = cyc;
            done_at  = cyc + (hif.MulDiv_Is_Div_EX ? DC : MC);
            m_sel    = hif.MulDiv_Is_Div_EX;
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic clear_inputs();
        hif.MemRead_ID_EX    = 1'b0;
        hif.Rt_ID_EX         = 5'd0;
        hif.Rs_IF_ID         = 5'd0;
        hif.Rt_IF_ID         = 5'd0;
        hif.Uses_Rt_ID       = 1'b0;
        hif.Branch_Taken_EX  = 1'b0;
        hif.MulDiv_Start_EX  = 1'b0;
        hif.MulDiv_Is_Div_EX = 1'b0;
        hif.HiLo_Read_ID     = 1'b0;
        hif.MulDiv_Op_ID     = 1'b0;
    endtask

    task automatic drain();
        clear_inputs();
        repeat (8) tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        model_reset();
        hif.MemRead_ID_EX = 1'b1;
        hif.Rt_ID_EX      = 5'd7;
        hif.Rs_IF_ID      = 5'd7;
        repeat (2) @(posedge clk);
        #3;
        total++; if (hif.MulDiv_Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", hif.MulDiv_Busy); else passed++;
        total++; if (hif.MulDiv_Done !== 1'b0) $display("FAIL reset_done got %b want 0", hif.MulDiv_Done); else passed++;
        total++; if (hif.MulDiv_Sel_Div !== 1'b0) $display("FAIL reset_sel got %b want 0", hif.MulDiv_Sel_Div); else passed++;
        total++; if (hif.PC_Write !== 1'b0) $display("FAIL reset_comb_pcw got %b want 0", hif.PC_Write); else passed++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        drain();
    endtask

    task automatic test_load_use();
        bit exp_pcw;
        for (int k = 0; k < 4; k++) begin
            clear_inputs();
            hif.MemRead_ID_EX = 1'b1;
            hif.Rt_ID_EX      = 5'd5;
            case (k)
                0: hif.Rs_IF_ID = 5'd5;
                1: begin hif.Rt_ID_EX = 5'd0; hif.Rs_IF_ID = 5'd0; end
                2: begin hif.Rs_IF_ID = 5'd3; hif.Rt_IF_ID = 5'd5; hif.Uses_Rt_ID = 1'b0; end
                default: begin hif.Rs_IF_ID = 5'd3; hif.Rt_IF_ID = 5'd5; hif.Uses_Rt_ID = 1'b1; end
            endcase
            exp_pcw = (k == 1 || k == 2);
            #2;
            total++; if (hif.PC_Write !== exp_pcw) $display("FAIL load_use_pcw case %0d got %b want %b", k, hif.PC_Write, exp_pcw); else passed++;
            total++; if (hif.IF_ID_Write !== exp_pcw) $display("FAIL load_use_ifidw case %0d got %b want %b", k, hif.IF_ID_Write, exp_pcw); else passed++;
            total++; if (hif.ID_EX_Flush !== !exp_pcw) $display("FAIL load_use_flush case %0d got %b want %b", k, hif.ID_EX_Flush, !exp_pcw); else passed++;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_mult_timing();
        drain();
        hif.MulDiv_Start_EX = 1'b1;
        #3;
        total++; if (hif.MulDiv_Busy !== 1'b0) $display("FAIL mult_c0_busy got %b want 0", hif.MulDiv_Busy); else passed++;
        for (int c = 1; c <= 6; c++) begin
            tick();
            clear_inputs();
            #3;
            total++; if (hif.MulDiv_Busy !== (c <= 3)) $display("FAIL mult_busy c%0d got %b want %b", c, hif.MulDiv_Busy, (c <= 3)); else passed++;
            total++; if (hif.MulDiv_Done !== (c == 4)) $display("FAIL mult_done c%0d got %b want %b", c, hif.MulDiv_Done, (c == 4)); else passed++;
            total++; if (hif.MulDiv_Sel_Div !== 1'b0) $display("FAIL mult_sel c%0d got %b want 0", c, hif.MulDiv_Sel_Div); else passed++;
        end
    endtask

    task automatic test_hilo_stall();
        drain();
        hif.MulDiv_Start_EX = 1'b1;
        hif.HiLo_Read_ID    = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) begin
                tick();
                hif.MulDiv_Start_EX = 1'b0;
            end
            #3;
            total++; if (hif.PC_Write !== (c >= 4)) $display("FAIL hilo_pcw c%0d got %b want %b", c, hif.PC_Write, (c >= 4)); else passed++;
            total++; if (hif.ID_EX_Flush !== (c <= 3)) $display("FAIL hilo_flush c%0d got %b want %b", c, hif.ID_EX_Flush, (c <= 3)); else passed++;
        end
        clear_inputs();
    endtask

    task automatic test_branch_flush();
        drain();
        hif.MulDiv_Start_EX = 1'b1;
        hif.HiLo_Read_ID    = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) begin
                tick();
                hif.MulDiv_Start_EX = 1'b0;
            end
            hif.Branch_Taken_EX = (c == 2);
            #3;
            total++; if (hif.PC_Write !== (c == 2 || c >= 4)) $display("FAIL br_pcw c%0d got %b want %b", c, hif.PC_Write, (c == 2 || c >= 4)); else passed++;
            total++; if (hif.IF_ID_Flush !== (c == 2)) $display("FAIL br_ifid_flush c%0d got %b want %b", c, hif.IF_ID_Flush, (c == 2)); else passed++;
            total++; if (hif.ID_EX_Flush !== (c <= 3)) $display("FAIL br_idex_flush c%0d got %b want %b", c, hif.ID_EX_Flush, (c <= 3)); else passed++;
            total++; if (hif.MulDiv_Busy !== (c >= 1 && c <= 3)) $display("FAIL br_busy c%0d got %b want %b", c, hif.MulDiv_Busy, (c >= 1 && c <= 3)); else passed++;
            total++; if (hif.MulDiv_Done !== (c == 4)) $display("FAIL br_done c%0d got %b want %b", c, hif.MulDiv_Done, (c == 4)); else passed++;
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        bit eb;
        drain();
        hif.MulDiv_Start_EX  = 1'b1;
        hif.MulDiv_Is_Div_EX = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            hif.MulDiv_Start_EX  = (c == 6);
            hif.MulDiv_Is_Div_EX = 1'b0;
            #3;
            eb = (c >= 1 && c <= 5) || (c >= 7 && c <= 9);
            total++; if (hif.MulDiv_Busy !== eb) $display("FAIL b2b_busy c%0d got %b want %b", c, hif.MulDiv_Busy, eb); else passed++;
            total++; if (hif.MulDiv_Done !== (c == 6 || c == 10)) $display("FAIL b2b_done c%0d got %b want %b", c, hif.MulDiv_Done, (c == 6 || c == 10)); else passed++;
            total++; if (hif.MulDiv_Sel_Div !== (c <= 6)) $display("FAIL b2b_sel c%0d got %b want %b", c, hif.MulDiv_Sel_Div, (c <= 6)); else passed++;
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_op();
        drain();
        hif.MulDiv_Start_EX = 1'b1;
        hif.HiLo_Read_ID    = 1'b1;
        tick();
        hif.MulDiv_Start_EX = 1'b0;
        tick();
        #3;
        total++; if (hif.MulDiv_Busy !== 1'b1) $display("FAIL rstmid_busy_before got %b want 1", hif.MulDiv_Busy); else passed++;
        total++; if (hif.PC_Write !== 1'b0) $display("FAIL rstmid_pcw_before got %b want 0", hif.PC_Write); else passed++;
        rst = 1'b0;
        model_reset();
        #1;
        total++; if (hif.MulDiv_Busy !== 1'b0) $display("FAIL rstmid_busy_async got %b want 0", hif.MulDiv_Busy); else passed++;
        total++; if (hif.PC_Write !== 1'b1) $display("FAIL rstmid_pcw_async got %b want 1", hif.PC_Write); else passed++;
        total++; if (hif.ID_EX_Flush !== 1'b0) $display("FAIL rstmid_flush_async got %b want 0", hif.ID_EX_Flush); else passed++;
        tick();
        rst = 1'b1;
        for (int c = 3; c <= 7; c++) begin
            tick();
            #3;
            total++; if (hif.MulDiv_Busy !== 1'b0) $display("FAIL rstmid_busy c%0d got %b want 0", c, hif.MulDiv_Busy); else passed++;
            total++; if (hif.MulDiv_Done !== 1'b0) $display("FAIL rstmid_done c%0d got %b want 0", c, hif.MulDiv_Done); else passed++;
            total++; if (hif.PC_Write !== 1'b1) $display("FAIL rstmid_pcw c%0d got %b want 1", c, hif.PC_Write); else passed++;
        end
        clear_inputs();
    endtask

    task automatic test_random();
        bit lu, hs, st, br, e_pcw, e_ifw, e_iff, e_ief;
        drain();
        for (int i = 0; i < 400; i++) begin
            tick();
            hif.MemRead_ID_EX    = $urandom_range(0, 1) == 1;
            hif.Rt_ID_EX         = 5'($urandom_range(0, 3));
            hif.Rs_IF_ID         = 5'($urandom_range(0, 3));
            hif.Rt_IF_ID         = 5'($urandom_range(0, 3));
            hif.Uses_Rt_ID       = $urandom_range(0, 1) == 1;
            hif.Branch_Taken_EX  = $urandom_range(0, 7) == 0;
            hif.MulDiv_Start_EX  = $urandom_range(0, 4) == 0;
            hif.MulDiv_Is_Div_EX = $urandom_range(0, 1) == 1;
            hif.HiLo_Read_ID     = $urandom_range(0, 2) == 0;
            hif.MulDiv_Op_ID     = $urandom_range(0, 3) == 0;
            #3;
            lu = hif.MemRead_ID_EX && (hif.Rt_ID_EX != 5'd0) &&
                 ((hif.Rt_ID_EX == hif.Rs_IF_ID) || (hif.Uses_Rt_ID && hif.Rt_ID_EX == hif.Rt_IF_ID));
            hs = (hif.HiLo_Read_ID || hif.MulDiv_Op_ID) && (m_busy() || hif.MulDiv_Start_EX);
            st = lu || hs;
            br = hif.Branch_Taken_EX;
            e_pcw = br || !st;
            e_ifw = br || !st;
            e_iff = br;
            e_ief = br || st;
            total++; if (hif.PC_Write !== e_pcw) $display("FAIL rnd_pcw i%0d got %b want %b", i, hif.PC_Write, e_pcw); else passed++;
            total++; if (hif.IF_ID_Write !== e_ifw) $display("FAIL rnd_ifidw i%0d got %b want %b", i, hif.IF_ID_Write, e_ifw); else passed++;
            total++; if (hif.IF_ID_Flush !== e_iff) $display("FAIL rnd_ifidf i%0d got %b want %b", i, hif.IF_ID_Flush, e_iff); else passed++;
            total++; if (hif.ID_EX_Flush !== e_ief) $display("FAIL rnd_idexf i%0d got %b want %b", i, hif.ID_EX_Flush, e_ief); else passed++;
            total++; if (hif.MulDiv_Busy !== m_busy()) $display("FAIL rnd_busy i%0d got %b want %b", i, hif.MulDiv_Busy, m_busy()); else passed++;
            total++; if (hif.MulDiv_Done !== m_done()) $display("FAIL rnd_done i%0d got %b want %b", i, hif.MulDiv_Done, m_done()); else passed++;
            total++; if (hif.MulDiv_Sel_Div !== m_sel) $display("FAIL rnd_sel i%0d got %b want %b", i, hif.MulDiv_Sel_Div, m_sel); else passed++;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mult_timing();
        test_hilo_stall();
        test_branch_flush();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
